instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage of the MIPS pipeline, directly upstream of InstructionMemory.
- Owns the program counter and drives the instruction-memory address. Takes back the combinational instruction word and registers it into the IF/ID pipeline register, with a valid bit.
- Handles pipeline stall, flush and branch/jump redirect requests from ID/EX.
- Keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- FLUSH_ON_REDIRECT, 1: 1 = a redirect squashes the wrong-path instruction in IF (bubble into IF/ID). 0 = MIPS delay-slot semantics; the IF instruction is kept.
- CNT_W, 32: width of FetchCount.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InstrAddress  out  32  byte address to InstructionMemory; equals PC combinationally.
- Instruction  in  32  word returned by InstructionMemory in the same cycle.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- Flush  in  1  force a bubble into IF/ID; PC unaffected unless Redirect.
- Redirect  in  1  taken branch, jump or jr resolved downstream.
- RedirectTarget  in  32  next PC when Redirect=1.
- IFID_Instruction  out  32  registered instruction.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  1 = IF/ID holds a real instruction.
- AlignErr  out  1  sticky: a misaligned RedirectTarget was received.
- FetchCount  out  CNT_W  number of instructions accepted into IF/ID with Valid=1.

Behaviour:
- Reset (Reset=0, asynchronous, any time including mid-stall or mid-redirect):
  - PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, AlignErr=0, FetchCount=0.
  - First rising edge after Reset deasserts captures Memory[RESET_PC>>2].
- Datapath:
  - InstrAddress=PC, purely combinational from the PC register; zero cycles of address latency.
  - The instruction for PC appears in IF/ID one edge later.
- Per rising edge, priority Redirect > Stall > normal:
  - Redirect=1:
    - PC <= {RedirectTarget[31:2],2'b00}; Redirect overrides Stall.
    - If RedirectTarget[1:0]!=0, AlignErr <= 1; it stays 1 until reset.
    - IF/ID: FLUSH_ON_REDIRECT=1 -> IFID_Valid<=0, IFID_Instruction<=0.
    - IF/ID: FLUSH_ON_REDIRECT=0 -> captures current Instruction/PC+4 with Valid=1, unless Flush or Stall applies.
  - Stall=1, Redirect=0:
    - PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid all hold; FetchCount holds.
  - Normal: PC <= PC+4; IF/ID <= {Instruction, PC+4, Valid=1}.
- Flush=1:
  - IF/ID gets a bubble (Valid=0, Instruction=0, PCPlus4=0) regardless of Stall. Flush beats Stall for IF/ID only.
  - PC follows the rules above.
- FetchCount increments by 1 on every edge where IF/ID is loaded with Valid=1.
  - Wraps modulo 2^CNT_W.
  - A held (stalled) entry is not recounted.
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC+4 wraps to 0.
  - Memory index aliasing is InstructionMemory's concern (it uses Address[11:2]).
- Bubble encoding: all-zero instruction (sll $0,$0,0, a nop), so downstream decoders need no special case.
- Redirect and Stall in the same cycle: PC takes the target. With FLUSH_ON_REDIRECT=0, IF/ID holds.
- No combinational path from Stall, Flush or Redirect to any output except through registers. InstrAddress depends only on the PC register.

Decomposition:
- Shared package/header (e.g. mips_defs):
  - NOP_INSTR = 32'h0000_0000
  - PC_INCR = 4
  - WORD_ALIGN_MASK = 32'hFFFF_FFFC
  - RESET_PC default
- One natural sub-module: ifid_pipe_reg. It holds the IF/ID register with load-enable (~Stall), bubble-insert (Flush or redirect squash) and asynchronous active-low reset, and is reusable for the later ID/EX stages.
- PC register, next-PC mux, alignment check and counter stay in the top module.

Test Plan:
- Reset low 3 cycles, release; memory holds word i = i*3 -> InstrAddress 0,4,8 on successive cycles; IFID_Instruction 0,3,6; IFID_PCPlus4 4,8,12; Valid=1; FetchCount=3 after 3 edges.
- Stall=1 for 2 cycles at PC=8 -> InstrAddress stays 8; IF/ID stays {3,8}; FetchCount frozen. On release, next IF/ID = {6,12}.
- Redirect=1, target 32'h40, FLUSH_ON_REDIRECT=1 -> next edge PC=0x40, Valid=0, Instruction=0. Following edge IF/ID = {48, 0x44}, Valid=1.
- Same redirect with FLUSH_ON_REDIRECT=0 -> wrong-path (delay-slot) instruction lands in IF/ID with Valid=1; PC=0x40.
- Redirect to 32'h43 -> PC=0x40, AlignErr=1 and stays 1 through later normal fetches until Reset.
- Assert Reset asynchronously mid-cycle during Stall+Redirect -> outputs go to reset values immediately, without a clock edge. PC 0xFFFF_FFFC with no stall -> next PC 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared constants and types for the MIPS fetch stage and its IF/ID register.
//   - NOP_INSTR        : bubble encoding (sll $0,$0,0)
//   - PC_INCR          : sequential fetch stride in bytes
//   - WORD_ALIGN_MASK  : clears the byte-offset bits of an address
//   - RESET_PC_DEFAULT : default reset vector
//   - ifid_t           : IF/ID payload (instruction word + its PC+4)
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } ifid_t;

    // A bubble is all zeros so downstream decode sees a plain nop.
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0000_0000};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_ifid_pipe_reg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_ifid_pipe_reg
//   Pipeline register between IF and ID with load-enable and bubble insert.
//   Bubble has priority over the load enable, so a flush lands even while the
//   stage is stalled. Written generically enough to reuse for later stages.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load_en  in   1 = capture d with valid=1 (deasserted on stall -> hold)
//   bubble   in   1 = capture an all-zero entry with valid=0
//   d        in   incoming payload
//   q        out  registered payload
//   valid    out  registered valid bit
// ---------------------------------------------------------------------------
module instruction_fetch_unit_ifid_pipe_reg
    import instruction_fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_en,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q,
    output logic  valid
);

    ifid_t data_q, data_d;
    logic  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (bubble) begin
            data_d  = IFID_BUBBLE;
            valid_d = 1'b0;
        end else if (load_en) begin
            data_d  = d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= IFID_BUBBLE;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   MIPS IF stage. Owns the PC, drives the instruction-memory address straight
//   from the PC register, and registers the returned word into IF/ID.
//   Next-PC priority: Redirect > Stall > sequential (PC+4, wraps at 2^32).
// Parameters:
//   RESET_PC          reset vector (word aligned)
//   FLUSH_ON_REDIRECT 1 = squash the wrong-path fetch on redirect,
//                     0 = keep it (branch delay slot)
//   CNT_W             width of FetchCount
// Ports:
//   Clk, Reset        clock / asynchronous active-low reset
//   InstrAddress      out  byte address to InstructionMemory (= PC)
//   Instruction       in   word for InstrAddress, same cycle
//   Stall             in   hold PC and IF/ID
//   Flush             in   bubble into IF/ID (PC unaffected)
//   Redirect          in   taken branch / jump resolved downstream
//   RedirectTarget    in   next PC when Redirect=1
//   IFID_Instruction  out  registered instruction
//   IFID_PCPlus4      out  registered PC+4 of that instruction
//   IFID_Valid        out  IF/ID holds a real instruction
//   AlignErr          out  sticky: a misaligned redirect target was seen
//   FetchCount        out  instructions accepted into IF/ID with Valid=1
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC          = RESET_PC_DEFAULT,
    parameter bit          FLUSH_ON_REDIRECT = 1'b1,
    parameter int          CNT_W             = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic [31:0]      InstrAddress,
    input  logic [31:0]      Instruction,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             Redirect,
    input  logic [31:0]      RedirectTarget,
    output logic [31:0]      IFID_Instruction,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic             AlignErr,
    output logic [CNT_W-1:0] FetchCount
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & WORD_ALIGN_MASK;

    logic [31:0]      pc_q, pc_d;
    logic             align_err_q, align_err_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic        squash;
    logic        load_valid;
    ifid_t       ifid_in, ifid_out;

    assign pc_plus4 = pc_q + PC_INCR;

    // Flush always bubbles IF/ID; a redirect only does when configured to
    // squash. With delay-slot semantics the redirect cycle behaves like a
    // normal fetch for IF/ID (still subject to Stall holding it).
    assign squash     = Flush | (Redirect & FLUSH_ON_REDIRECT);
    assign load_valid = ~squash & ~Stall;

    always_comb begin
        pc_d          = pc_q;
        align_err_d   = align_err_q;
        fetch_count_d = fetch_count_q;

        if (Redirect) begin
            pc_d = word_align(RedirectTarget);
            if (is_misaligned(RedirectTarget)) begin
                align_err_d = 1'b1;
            end
        end else if (!Stall) begin
            pc_d = pc_plus4;
        end

        if (load_valid) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q          <= RESET_PC_ALIGNED;
            align_err_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            align_err_q   <= align_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign ifid_in = '{instr: Instruction, pc_plus4: pc_plus4};

    instruction_fetch_unit_ifid_pipe_reg u_ifid (
        .clk     (Clk),
        .rst_n   (Reset),
        .load_en (~Stall),
        .bubble  (squash),
        .d       (ifid_in),
        .q       (ifid_out),
        .valid   (IFID_Valid)
    );

    assign InstrAddress     = pc_q;
    assign IFID_Instruction = ifid_out.instr;
    assign IFID_PCPlus4     = ifid_out.pc_plus4;
    assign AlignErr         = align_err_q;
    assign FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Two instances share the control inputs: u0 squashes on redirect with a
// 32-bit counter, u1 keeps the delay slot with a 3-bit counter so wrap is
// reached quickly. Each has its own memory model: word i holds i*3.
module tb_instruction_fetch_unit;

    logic        Clk, Reset, Stall, Flush, Redirect;
    logic [31:0] RedirectTarget;

    logic [31:0] addr0, instr0, ifi0, ifp0, cnt0;
    logic        v0, ae0;
    logic [31:0] addr1, instr1, ifi1, ifp1;
    logic [2:0]  cnt1;
    logic        v1, ae1;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return {22'd0, a[11:2]} * 32'd3;
    endfunction

    assign instr0 = mem_rd(addr0);
    assign instr1 = mem_rd(addr1);

    instruction_fetch_unit #(.RESET_PC(32'h0), .FLUSH_ON_REDIRECT(1'b1), .CNT_W(32)) u0 (
        .Clk(Clk), .Reset(Reset), .InstrAddress(addr0), .Instruction(instr0),
        .Stall(Stall), .Flush(Flush), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
        .IFID_Instruction(ifi0), .IFID_PCPlus4(ifp0), .IFID_Valid(v0),
        .AlignErr(ae0), .FetchCount(cnt0));

    instruction_fetch_unit #(.RESET_PC(32'h0), .FLUSH_ON_REDIRECT(1'b0), .CNT_W(3)) u1 (
        .Clk(Clk), .Reset(Reset), .InstrAddress(addr1), .Instruction(instr1),
        .Stall(Stall), .Flush(Flush), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
        .IFID_Instruction(ifi1), .IFID_PCPlus4(ifp1), .IFID_Valid(v1),
        .AlignErr(ae1), .FetchCount(cnt1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] pc, instr, pc4, cnt;
        logic        valid, align;
    } mstate_t;

    function automatic mstate_t mreset();
        mstate_t s;
        s.pc = 0; s.instr = 0; s.pc4 = 0; s.cnt = 0; s.valid = 0; s.align = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input bit squash_redir, input int cbits,
                                      input logic st, input logic fl, input logic rd,
                                      input logic [31:0] tg);
        mstate_t n = s;
        if (rd) begin
            n.pc = {tg[31:2], 2'b00};
            if (tg[1:0] != 2'b00) n.align = 1'b1;
        end else if (!st) begin
            n.pc = s.pc + 32'd4;
        end
        if (fl || (rd && squash_redir)) begin
            n.instr = 0; n.pc4 = 0; n.valid = 0;
        end else if (!st) begin
            n.instr = mem_rd(s.pc);
            n.pc4   = s.pc + 32'd4;
            n.valid = 1'b1;
            n.cnt   = 32'((64'(s.cnt) + 64'd1) % (64'd1 << cbits));
        end
        return n;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall, flush, redir;
        logic [31:0] target;
        logic [31:0] addr;
        logic        align;
        logic [31:0] i0, p0; logic vv0; logic [31:0] c0;
        logic [31:0] i1, p1; logic vv1; logic [31:0] c1;
    } vec_t;

    vec_t tbl[13];

    mstate_t m0, m1;

    initial begin
        tbl[0]  = '{0,0,0,32'h00, 32'h04,0,  0,32'h04,1,1,  0,32'h04,1,1};
        tbl[1]  = '{0,0,0,32'h00, 32'h08,0,  3,32'h08,1,2,  3,32'h08,1,2};
        tbl[2]  = '{1,0,0,32'h00, 32'h08,0,  3,32'h08,1,2,  3,32'h08,1,2};
        tbl[3]  = '{1,0,0,32'h00, 32'h08,0,  3,32'h08,1,2,  3,32'h08,1,2};
        tbl[4]  = '{0,0,0,32'h00, 32'h0C,0,  6,32'h0C,1,3,  6,32'h0C,1,3};
        tbl[5]  = '{0,0,1,32'h40, 32'h40,0,  0,32'h00,0,3,  9,32'h10,1,4};
        tbl[6]  = '{0,0,0,32'h00, 32'h44,0, 48,32'h44,1,4, 48,32'h44,1,5};
        tbl[7]  = '{0,0,1,32'h43, 32'h40,1,  0,32'h00,0,4, 51,32'h48,1,6};
        tbl[8]  = '{0,0,0,32'h00, 32'h44,1, 48,32'h44,1,5, 48,32'h44,1,7};
        tbl[9]  = '{0,1,0,32'h00, 32'h48,1,  0,32'h00,0,5,  0,32'h00,0,7};
        tbl[10] = '{1,1,0,32'h00, 32'h48,1,  0,32'h00,0,5,  0,32'h00,0,7};
        tbl[11] = '{1,0,1,32'h80, 32'h80,1,  0,32'h00,0,5,  0,32'h00,0,7};
        tbl[12] = '{0,0,0,32'h00, 32'h84,1, 96,32'h84,1,6, 96,32'h84,1,0};

        Reset = 1'b0; Stall = 0; Flush = 0; Redirect = 0; RedirectTarget = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_u0", {addr0, ifi0, ifp0, v0, ae0, cnt0}, 160'd0);
        chk("reset_u1", {addr1, ifi1, ifp1, v1, ae1, cnt1}, 160'd0);
        Reset = 1'b1;

        for (int r = 0; r < 13; r++) begin
            Stall = tbl[r].stall; Flush = tbl[r].flush;
            Redirect = tbl[r].redir; RedirectTarget = tbl[r].target;
            @(posedge Clk); #1;
            chk($sformatf("tbl%0d_addr0", r), {addr0, ae0}, {tbl[r].addr, tbl[r].align});
            chk($sformatf("tbl%0d_addr1", r), {addr1, ae1}, {tbl[r].addr, tbl[r].align});
            chk($sformatf("tbl%0d_ifid0", r), {ifi0, ifp0, v0, cnt0},
                {tbl[r].i0, tbl[r].p0, tbl[r].vv0, tbl[r].c0});
            chk($sformatf("tbl%0d_ifid1", r), {ifi1, ifp1, v1, cnt1},
                {tbl[r].i1, tbl[r].p1, tbl[r].vv1, tbl[r].c1[2:0]});
        end

        // PC wrap at the top of the address space
        Stall = 0; Flush = 0; Redirect = 1; RedirectTarget = 32'hFFFF_FFFC;
        @(posedge Clk); #1;
        chk("wrap_pc_top", addr0, 32'hFFFF_FFFC);
        Redirect = 0;
        @(posedge Clk); #1;
        chk("wrap_pc_zero", addr0, 32'h0);
        chk("wrap_ifid", {ifi0, ifp0, v0}, {32'd3069, 32'h0, 1'b1});

        // asynchronous reset mid-cycle while Stall and Redirect are both high
        Stall = 1; Redirect = 1; RedirectTarget = 32'h100;
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_u0", {addr0, ifi0, ifp0, v0, ae0, cnt0}, 160'd0);
        chk("async_rst_u1", {addr1, ifi1, ifp1, v1, ae1, cnt1}, 160'd0);
        Stall = 0; Redirect = 0; RedirectTarget = 0;
        @(negedge Clk) Reset = 1'b1;
        @(posedge Clk); #1;
        chk("post_rst_first", {addr0, ifi0, ifp0, v0, cnt0}, {32'h4, 32'h0, 32'h4, 1'b1, 32'd1});

        // randomized run against the reference model
        Reset = 1'b0;
        #2 Reset = 1'b1;
        m0 = mreset(); m1 = mreset();
        for (int k = 0; k < 400; k++) begin
            Stall    = ($urandom_range(0, 3) == 0);
            Flush    = ($urandom_range(0, 9) == 0);
            Redirect = ($urandom_range(0, 9) == 0);
            RedirectTarget = $urandom();
            if ($urandom_range(0, 3) != 0) RedirectTarget[1:0] = 2'b00;
            m0 = mstep(m0, 1'b1, 32, Stall, Flush, Redirect, RedirectTarget);
            m1 = mstep(m1, 1'b0, 3,  Stall, Flush, Redirect, RedirectTarget);
            @(posedge Clk); #1;
            chk($sformatf("rnd%0d_u0", k), {addr0, ifi0, ifp0, v0, ae0, cnt0},
                {m0.pc, m0.instr, m0.pc4, m0.valid, m0.align, m0.cnt});
            chk($sformatf("rnd%0d_u1", k), {addr1, ifi1, ifp1, v1, ae1, cnt1},
                {m1.pc, m1.instr, m1.pc4, m1.valid, m1.align, m1.cnt[2:0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
